// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serialises 8-bit DAC codes into 16-bit SPI mode-0 frames
// {CMD, sample, 4'b0000}, MSB first. A single pending register with
// valid/ready decouples the core from the frame timing. Every SPI pin and
// status output comes straight from a flop, so the pins stay glitch-free.
module dac_spi_tx #(
    parameter int         CLK_DIV = 4,
    parameter logic [3:0] CMD     = 4'h3
) (
    input  logic       core_clk,
    input  logic       core_reset,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    output logic       sample_ready,
    output logic       busy,
    output logic       frame_done,
    output logic       spi_sclk,
    output logic       spi_mosi,
    output logic       spi_cs_n
);

    // The divider counts 0..CLK_DIV-1. It is kept at least 1 bit wide so
    // that a CLK_DIV=1 build still has a legal vector.
    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_CS_HOLD  = 3'd3,
        ST_GAP      = 3'd4
    } state_e;

    // Builds the 16-bit word that goes out on the wire for one DAC code.
    function automatic logic [15:0] build_frame(input logic [7:0] code);
        return {CMD, code, 4'b0000};
    endfunction

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [15:0]      shift_q, shift_d;
    logic [7:0]       pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    logic             ready_q, ready_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             cs_n_q, cs_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             phase_end_s;
    logic             accept_s;
    logic [15:0]      load_frame_s;

    assign phase_end_s  = (div_q == DIV_LAST);
    assign accept_s     = sample_valid & ready_q;
    assign load_frame_s = build_frame(pend_q);

    // Next-state logic: FSM sequencing, divider, shifter and pending register.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        cs_n_d      = cs_n_q;
        done_d      = 1'b0;

        // The divider only runs while a frame is in flight; every phase
        // starts with it at zero.
        if (state_q == ST_IDLE) begin
            div_d = '0;
        end else if (phase_end_s) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end

        // Accept and load are mutually exclusive: accept needs the pending
        // register empty, load needs it full.
        if (accept_s) begin
            pend_d      = sample_in;
            pend_full_d = 1'b1;
        end else begin
            pend_d      = pend_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (pend_full_q) begin
                    shift_d     = load_frame_s;
                    mosi_d      = load_frame_s[15];
                    cs_n_d      = 1'b0;
                    sclk_d      = 1'b0;
                    bit_cnt_d   = 4'd0;
                    pend_full_d = 1'b0;
                    state_d     = ST_CS_SETUP;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_CS_SETUP: begin
                if (phase_end_s) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_CS_SETUP;
                end
            end
            ST_SHIFT: begin
                if (!phase_end_s) begin
                    state_d = ST_SHIFT;
                end else if (!sclk_q) begin
                    // Rising edge: the DAC samples the bit already on mosi.
                    sclk_d = 1'b1;
                end else begin
                    // Falling edge: present the next bit; a zero shifts in
                    // behind, so mosi is low once the 16th bit is done.
                    sclk_d    = 1'b0;
                    shift_d   = {shift_q[14:0], 1'b0};
                    mosi_d    = shift_q[14];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) begin
                        state_d = ST_CS_HOLD;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_CS_HOLD: begin
                if (phase_end_s) begin
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_CS_HOLD;
                end
            end
            ST_GAP: begin
                if (phase_end_s) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
            end
        endcase

        busy_d  = (state_d != ST_IDLE);
        ready_d = ~pend_full_d;
    end

    // State and output registers; reset parks the pins in their idle levels.
    always_ff @(posedge core_clk or posedge core_reset) begin
        if (core_reset) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 16'h0000;
            pend_q      <= 8'h00;
            pend_full_q <= 1'b0;
            ready_q     <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            ready_q     <= ready_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            cs_n_q      <= cs_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign sample_ready = ready_q;
    assign busy         = busy_q;
    assign frame_done   = done_q;
    assign spi_sclk     = sclk_q;
    assign spi_mosi     = mosi_q;
    assign spi_cs_n     = cs_n_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: two instances (CLK_DIV=4 and CLK_DIV=1) share one clock and
// reset. A timeline model gives every output as a function of the cycles
// elapsed since the load edge. The outputs are compared against it on every
// falling clock edge. Captured SPI words and timing figures are checked
// against hand-computed literals.
module tb_dac_spi_tx;

    localparam logic [3:0] CMD = 4'h3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din [2];
    logic       vld [2];
    logic       rdy [2];
    logic       bsy [2];
    logic       dne [2];
    logic       sclk [2];
    logic       mosi [2];
    logic       csn [2];

    dac_spi_tx #(.CLK_DIV(4), .CMD(CMD)) u_div4 (
        .core_clk(clk), .core_reset(rst), .sample_in(din[0]), .sample_valid(vld[0]),
        .sample_ready(rdy[0]), .busy(bsy[0]), .frame_done(dne[0]),
        .spi_sclk(sclk[0]), .spi_mosi(mosi[0]), .spi_cs_n(csn[0]));

    dac_spi_tx #(.CLK_DIV(1), .CMD(CMD)) u_div1 (
        .core_clk(clk), .core_reset(rst), .sample_in(din[1]), .sample_valid(vld[1]),
        .sample_ready(rdy[1]), .busy(bsy[1]), .frame_done(dne[1]),
        .spi_sclk(sclk[1]), .spi_mosi(mosi[1]), .spi_cs_n(csn[1]));

    // Free-running core clock, period 10.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: frame timeline plus the pending slot.
    bit          m_act  [2];
    int          m_t    [2];
    logic [15:0] m_frame[2];
    bit          m_pf   [2];
    logic [7:0]  m_pv   [2];
    bit          m_done [2];

    // Observation state.
    bit          p_sclk [2];
    bit          p_cs   [2];
    bit          p_busy [2];
    logic [15:0] wd     [2];
    int          nb     [2];
    logic [15:0] last_word[2];
    int          nwords [2];
    int          ndone  [2];
    int          hi_run [2];
    int          last_hi[2];
    int          busy_run[2];
    int          last_busy[2];
    int          last_fall[2];
    int          last_gap[2];
    int          last_rise[2];
    int          last_per[2];
    logic [15:0] cap_q[$];

    function automatic int dv(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_act[i]  = 1'b0;
            m_t[i]    = 0;
            m_pf[i]   = 1'b0;
            m_done[i] = 1'b0;
        end
    endtask

    // One rising edge of the model, using inputs as the DUT sees them.
    task automatic model_step();
        bit acc;
        if (rst) begin
            model_clear();
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit was_idle;
                acc       = vld[i] && !m_pf[i];
                was_idle  = !m_act[i];
                m_done[i] = 1'b0;
                if (m_act[i]) begin
                    m_t[i]++;
                    if (m_t[i] == 35 * dv(i)) begin
                        m_act[i]  = 1'b0;
                        m_done[i] = 1'b1;
                    end
                end
                if (was_idle && m_pf[i]) begin
                    m_act[i]   = 1'b1;
                    m_t[i]     = 0;
                    m_frame[i] = {CMD, m_pv[i], 4'h0};
                    m_pf[i]    = 1'b0;
                end
                if (acc) begin
                    m_pf[i] = 1'b1;
                    m_pv[i] = din[i];
                end
            end
        end
    endtask

    // Expected {ready, busy, done, sclk, mosi, cs_n} from the timeline.
    function automatic logic [5:0] exp_vec(input int i);
        int  d, t, h;
        logic sc, mo, cs, bz;
        d  = dv(i);
        t  = m_t[i];
        sc = 1'b0; mo = 1'b0; cs = 1'b1; bz = 1'b0;
        if (m_act[i]) begin
            bz = 1'b1;
            if (t < d) begin
                cs = 1'b0; mo = m_frame[i][15];
            end else if (t < 33 * d) begin
                h  = (t - d) / d;
                cs = 1'b0;
                sc = ((h % 2) == 1);
                mo = m_frame[i][15 - h / 2];
            end else if (t < 34 * d) begin
                cs = 1'b0;
            end
        end
        return {!m_pf[i], bz, m_done[i], sc, mo, cs};
    endfunction

    // Per-cycle comparison, SPI word capture and timing measurements.
    task automatic observe();
        logic [5:0] ev, av;
        for (int i = 0; i < 2; i++) begin
            ev = exp_vec(i);
            av = {rdy[i], bsy[i], dne[i], sclk[i], mosi[i], csn[i]};
            checks++;
            if (av !== ev) begin
                errors++;
                $display("FAIL cycle_model inst%0d cycle %0d: got %b expected %b (ready,busy,done,sclk,mosi,cs_n)",
                         i, cyc, av, ev);
            end
            if (sclk[i] && !p_sclk[i] && !csn[i]) begin
                wd[i] = {wd[i][14:0], mosi[i]};
                nb[i]++;
            end
            if (csn[i] && !p_cs[i]) begin
                if (nb[i] == 16) begin
                    chk($sformatf("spi_word_inst%0d", i), {16'h0000, wd[i]}, {16'h0000, m_frame[i]});
                    last_word[i] = wd[i];
                    nwords[i]++;
                    if (i == 0) cap_q.push_back(wd[i]);
                end
                nb[i] = 0;
            end
            if (csn[i]) begin
                hi_run[i]++;
            end else if (p_cs[i]) begin
                last_hi[i]   = hi_run[i];
                hi_run[i]    = 0;
                last_gap[i]  = cyc - last_fall[i];
                last_fall[i] = cyc;
            end
            if (bsy[i]) begin
                busy_run[i]++;
            end else if (p_busy[i]) begin
                last_busy[i] = busy_run[i];
                busy_run[i]  = 0;
            end
            if (sclk[i] && !p_sclk[i]) begin
                last_per[i]  = cyc - last_rise[i];
                last_rise[i] = cyc;
            end
            if (dne[i]) ndone[i]++;
            p_sclk[i] = sclk[i];
            p_cs[i]   = csn[i];
            p_busy[i] = bsy[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        observe();
    endtask

    // Offer one sample until accepted (bounded), then drop valid.
    task automatic send(input int i, input logic [7:0] v);
        int n;
        din[i] = v;
        vld[i] = 1'b1;
        n = 0;
        while (!rdy[i] && n < 2000) begin
            tick();
            n++;
        end
        chk($sformatf("send_timeout_inst%0d", i), {31'd0, (n >= 2000)}, 32'd0);
        tick();
        vld[i] = 1'b0;
    endtask

    task automatic wait_ndone(input int i, input int target);
        int n;
        n = 0;
        while (ndone[i] < target && n < 3000) begin
            tick();
            n++;
        end
        chk($sformatf("done_timeout_inst%0d", i), {31'd0, (ndone[i] < target)}, 32'd0);
    endtask

    int base_done, base_words, n;

    // Directed scenarios, then randomized traffic on both instances.
    initial begin
        for (int i = 0; i < 2; i++) begin
            din[i] = 8'h00; vld[i] = 1'b0;
            p_sclk[i] = 1'b0; p_cs[i] = 1'b1; p_busy[i] = 1'b0;
            wd[i] = 16'h0000; nb[i] = 0; last_word[i] = 16'h0000; nwords[i] = 0;
            ndone[i] = 0; hi_run[i] = 0; last_hi[i] = 0; busy_run[i] = 0; last_busy[i] = 0;
            last_fall[i] = 0; last_gap[i] = 0; last_rise[i] = 0; last_per[i] = 0;
            m_frame[i] = 16'h0000; m_pv[i] = 8'h00;
        end
        model_clear();
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_cs_n", {31'd0, csn[0]}, 32'd1);
        chk("reset_ready", {31'd0, rdy[0]}, 32'd1);
        repeat (3) tick();

        // Single frame with 0xA5.
        base_done = ndone[0];
        send(0, 8'hA5);
        chk("cs_before_load", {31'd0, csn[0]}, 32'd1);
        tick();
        chk("cs_after_load", {31'd0, csn[0]}, 32'd0);
        chk("model_frame_a5", {16'h0000, m_frame[0]}, 32'h3A50);
        wait_ndone(0, base_done + 1);
        chk("busy_len", last_busy[0], 32'd140);
        chk("word_a5", {16'h0000, last_word[0]}, 32'h3A50);
        repeat (5) tick();
        chk("done_once", ndone[0] - base_done, 32'd1);

        // Three samples with valid held high; back-to-back timing.
        cap_q.delete();
        base_done = ndone[0];
        send(0, 8'h11);
        chk("ready_low_11", {31'd0, rdy[0]}, 32'd0);
        send(0, 8'h22);
        chk("ready_low_22", {31'd0, rdy[0]}, 32'd0);
        send(0, 8'h33);
        chk("ready_low_33", {31'd0, rdy[0]}, 32'd0);
        wait_ndone(0, base_done + 3);
        chk("b2b_count", cap_q.size(), 32'd3);
        if (cap_q.size() == 3) begin
            chk("b2b_word0", {16'h0000, cap_q[0]}, 32'h3110);
            chk("b2b_word1", {16'h0000, cap_q[1]}, 32'h3220);
            chk("b2b_word2", {16'h0000, cap_q[2]}, 32'h3330);
        end
        chk("load_to_load", last_gap[0], 32'd141);
        chk("cs_high_between", last_hi[0], 32'd5);
        chk("sclk_period", last_per[0], 32'd8);

        // Reset after the 7th sclk rise with a sample pending.
        send(0, 8'h77);
        send(0, 8'h88);
        n = 0;
        while (nb[0] < 7 && n < 2000) begin
            tick();
            n++;
        end
        chk("seventh_rise", nb[0], 32'd7);
        base_done  = ndone[0];
        base_words = nwords[0];
        @(posedge clk);
        model_step();
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        chk("midrst_cs_n", {31'd0, csn[0]}, 32'd1);
        chk("midrst_sclk", {31'd0, sclk[0]}, 32'd0);
        chk("midrst_mosi", {31'd0, mosi[0]}, 32'd0);
        chk("midrst_ready", {31'd0, rdy[0]}, 32'd1);
        chk("midrst_busy", {31'd0, bsy[0]}, 32'd0);
        @(negedge clk);
        cyc++;
        observe();
        rst = 1'b0;
        repeat (200) tick();
        chk("midrst_no_done", ndone[0] - base_done, 32'd0);
        chk("midrst_no_word", nwords[0] - base_words, 32'd0);
        send(0, 8'h5A);
        wait_ndone(0, base_done + 1);
        chk("word_after_reset", {16'h0000, last_word[0]}, 32'h35A0);

        // CLK_DIV=1 instance: two back-to-back 0xFF frames.
        base_done = ndone[1];
        send(1, 8'hFF);
        send(1, 8'hFF);
        wait_ndone(1, base_done + 2);
        chk("div1_word", {16'h0000, last_word[1]}, 32'h3FF0);
        chk("div1_load_to_load", last_gap[1], 32'd36);
        chk("div1_sclk_period", last_per[1], 32'd2);
        chk("div1_cs_high", last_hi[1], 32'd2);

        // Randomized valid and data on both instances.
        for (int k = 0; k < 4000; k++) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                vld[i] = ($urandom_range(0, 3) == 0);
                din[i] = 8'($urandom);
            end
        end
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        repeat (400) tick();
        chk("drained_busy0", {31'd0, bsy[0]}, 32'd0);
        chk("drained_busy1", {31'd0, bsy[1]}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
